// File: rtl/id_stage_fwd_pkg.sv
// Shared decode constants and types for the id_stage_fwd decode stage.
// The optional writeback bypass is enabled with `define ID_WB_BYPASS_EN.
package id_stage_fwd_pkg;

    localparam int unsigned ALUOP_W = 10;
    localparam logic [ALUOP_W-1:0] ALUOP_NOP = '0;
    localparam logic RST_ENABLE   = 1'b1;
    localparam logic READ_ENABLE  = 1'b1;
    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic [4:0] ZERO_REG = 5'd0;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111
    } opcode_t;

    typedef struct packed {
        logic [ALUOP_W-1:0] aluop;
        logic               re1;
        logic               re2;
        logic               we;
        logic               mem_rd;
        logic               illegal;
    } dec_t;

endpackage

// File: rtl/id_stage_fwd_if.sv
// Handshake, regfile, forwarding and ID/EX bundle of the decode stage.
// wb_* signals exist only when ID_WB_BYPASS_EN is defined.
interface id_stage_fwd_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned NUM_FWD = 2
);

    logic                       in_valid_i;
    logic                       in_ready_o;
    logic [XLEN-1:0]            inst_addr_i;
    logic [31:0]                inst_i;
    logic                       flush_i;
    logic [RADDR_W-1:0]         reg1_raddr_o;
    logic [RADDR_W-1:0]         reg2_raddr_o;
    logic                       reg1_re_o;
    logic                       reg2_re_o;
    logic [XLEN-1:0]            reg1_rdata_i;
    logic [XLEN-1:0]            reg2_rdata_i;
    logic [NUM_FWD-1:0]         fwd_we_i;
    logic [NUM_FWD*RADDR_W-1:0] fwd_waddr_i;
    logic [NUM_FWD*XLEN-1:0]    fwd_wdata_i;
    logic [NUM_FWD-1:0]         fwd_pend_i;
`ifdef ID_WB_BYPASS_EN
    logic                       wb_we_i;
    logic [RADDR_W-1:0]         wb_waddr_i;
    logic [XLEN-1:0]            wb_wdata_i;
`endif
    logic                       out_valid_o;
    logic                       out_ready_i;
    logic [XLEN-1:0]            inst_addr_o;
    logic [9:0]                 aluop_o;
    logic [XLEN-1:0]            op1_o;
    logic [XLEN-1:0]            op2_o;
    logic                       reg_we_o;
    logic [RADDR_W-1:0]         reg_waddr_o;
    logic                       mem_rd_o;
    logic                       illegal_o;

    modport master (
        output in_valid_i, inst_addr_i, inst_i, flush_i,
        output reg1_rdata_i, reg2_rdata_i,
        output fwd_we_i, fwd_waddr_i, fwd_wdata_i, fwd_pend_i,
`ifdef ID_WB_BYPASS_EN
        output wb_we_i, wb_waddr_i, wb_wdata_i,
`endif
        output out_ready_i,
        input  in_ready_o, reg1_raddr_o, reg2_raddr_o, reg1_re_o, reg2_re_o,
        input  out_valid_o, inst_addr_o, aluop_o, op1_o, op2_o,
        input  reg_we_o, reg_waddr_o, mem_rd_o, illegal_o
    );

    modport slave (
        input  in_valid_i, inst_addr_i, inst_i, flush_i,
        input  reg1_rdata_i, reg2_rdata_i,
        input  fwd_we_i, fwd_waddr_i, fwd_wdata_i, fwd_pend_i,
`ifdef ID_WB_BYPASS_EN
        input  wb_we_i, wb_waddr_i, wb_wdata_i,
`endif
        input  out_ready_i,
        output in_ready_o, reg1_raddr_o, reg2_raddr_o, reg1_re_o, reg2_re_o,
        output out_valid_o, inst_addr_o, aluop_o, op1_o, op2_o,
        output reg_we_o, reg_waddr_o, mem_rd_o, illegal_o
    );

endinterface

// File: rtl/id_stage_fwd_mux.sv
// id_fwd_mux: per-port operand resolution over prioritised forwarding sources
// (source 0 highest), optional writeback bypass (ID_WB_BYPASS_EN), then regfile.
module id_fwd_mux #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned NUM_FWD = 2
) (
    input  logic [RADDR_W-1:0]         raddr,
    input  logic                       re,
    input  logic [NUM_FWD-1:0]         fwd_we,
    input  logic [NUM_FWD*RADDR_W-1:0] fwd_waddr,
    input  logic [NUM_FWD*XLEN-1:0]    fwd_wdata,
    input  logic [NUM_FWD-1:0]         fwd_pend,
`ifdef ID_WB_BYPASS_EN
    input  logic                       wb_we,
    input  logic [RADDR_W-1:0]         wb_waddr,
    input  logic [XLEN-1:0]            wb_wdata,
`endif
    input  logic [XLEN-1:0]            rdata,
    output logic [XLEN-1:0]            data,
    output logic                       pend
);

    logic hit;

    always_comb begin
        data = rdata;
        pend = 1'b0;
        hit  = 1'b0;
`ifdef ID_WB_BYPASS_EN
        if (wb_we && (wb_waddr == raddr)) begin
            data = wb_wdata;
        end
`endif
        // first hit wins, so younger sources shadow older ones and the wb bypass
        for (int unsigned k = 0; k < NUM_FWD; k++) begin
            if (!hit && fwd_we[k] && (fwd_waddr[k*RADDR_W +: RADDR_W] == raddr)) begin
                hit  = 1'b1;
                data = fwd_wdata[k*XLEN +: XLEN];
                pend = fwd_pend[k];
            end
        end
        if (!re || (raddr == '0)) begin
            data = '0;
            pend = 1'b0;
        end
    end

endmodule

// File: rtl/id_stage_fwd.sv
// Decode stage: RV32I OP/OP-IMM/LOAD/LUI decode, forwarding, load-use interlock, ID/EX register.
// Optional writeback bypass source enabled with `define ID_WB_BYPASS_EN.
module id_stage_fwd #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned NUM_FWD = 2
) (
    input logic          clk_i,
    input logic          rst_i,
    id_stage_fwd_if.slave bus
);

    import id_stage_fwd_pkg::*;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm;
    dec_t            dec;

    assign opcode = bus.inst_i[6:0];
    assign rd     = bus.inst_i[11:7];
    assign funct3 = bus.inst_i[14:12];
    assign rs1    = bus.inst_i[19:15];
    assign rs2    = bus.inst_i[24:20];
    assign imm_i  = XLEN'($signed(bus.inst_i[31:20]));
    assign imm_u  = XLEN'($signed({bus.inst_i[31:12], 12'b0}));

    always_comb begin
        dec       = '0;
        dec.aluop = ALUOP_NOP;
        imm       = '0;
        case (opcode_t'(opcode))
            OPC_OP_IMM: begin
                dec.re1   = READ_ENABLE;
                dec.we    = WRITE_ENABLE;
                dec.aluop = {funct3, opcode};
                imm       = imm_i;
            end
            OPC_OP: begin
                dec.re1   = READ_ENABLE;
                dec.re2   = READ_ENABLE;
                dec.we    = WRITE_ENABLE;
                dec.aluop = {funct3, opcode};
            end
            OPC_LOAD: begin
                dec.re1    = READ_ENABLE;
                dec.we     = WRITE_ENABLE;
                dec.mem_rd = 1'b1;
                dec.aluop  = {funct3, opcode};
                imm        = imm_i;
            end
            OPC_LUI: begin
                dec.we    = WRITE_ENABLE;
                dec.aluop = {funct3, opcode};
                imm       = imm_u;
            end
            default: dec.illegal = 1'b1;
        endcase
        if (rd == ZERO_REG) begin
            dec.we = 1'b0;
        end
    end

    assign bus.reg1_raddr_o = RADDR_W'(rs1);
    assign bus.reg2_raddr_o = RADDR_W'(rs2);
    assign bus.reg1_re_o    = dec.re1;
    assign bus.reg2_re_o    = dec.re2;

    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic            pend1;
    logic            pend2;

    id_fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W), .NUM_FWD(NUM_FWD)) u_mux1 (
        .raddr     (bus.reg1_raddr_o),
        .re        (dec.re1),
        .fwd_we    (bus.fwd_we_i),
        .fwd_waddr (bus.fwd_waddr_i),
        .fwd_wdata (bus.fwd_wdata_i),
        .fwd_pend  (bus.fwd_pend_i),
`ifdef ID_WB_BYPASS_EN
        .wb_we     (bus.wb_we_i),
        .wb_waddr  (bus.wb_waddr_i),
        .wb_wdata  (bus.wb_wdata_i),
`endif
        .rdata     (bus.reg1_rdata_i),
        .data      (data1),
        .pend      (pend1)
    );

    id_fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W), .NUM_FWD(NUM_FWD)) u_mux2 (
        .raddr     (bus.reg2_raddr_o),
        .re        (dec.re2),
        .fwd_we    (bus.fwd_we_i),
        .fwd_waddr (bus.fwd_waddr_i),
        .fwd_wdata (bus.fwd_wdata_i),
        .fwd_pend  (bus.fwd_pend_i),
`ifdef ID_WB_BYPASS_EN
        .wb_we     (bus.wb_we_i),
        .wb_waddr  (bus.wb_waddr_i),
        .wb_wdata  (bus.wb_wdata_i),
`endif
        .rdata     (bus.reg2_rdata_i),
        .data      (data2),
        .pend      (pend2)
    );

    logic [XLEN-1:0]    op2_sel;
    logic               stall;
    logic               fire;
    logic               out_valid;
    logic [XLEN-1:0]    inst_addr_q;
    logic [ALUOP_W-1:0] aluop_q;
    logic [XLEN-1:0]    op1_q;
    logic [XLEN-1:0]    op2_q;
    logic               we_q;
    logic [RADDR_W-1:0] waddr_q;
    logic               mem_rd_q;
    logic               illegal_q;

    assign op2_sel = dec.re2 ? data2 : imm;
    // a pending producer only matters when there is an instruction to decode
    assign stall   = bus.in_valid_i && (pend1 || pend2);
    assign bus.in_ready_o = (rst_i == RST_ENABLE) ||
                            (!stall && (!out_valid || bus.out_ready_i));
    assign fire    = bus.in_valid_i && bus.in_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i == RST_ENABLE) begin
            out_valid   <= 1'b0;
            inst_addr_q <= '0;
            aluop_q     <= ALUOP_NOP;
            op1_q       <= '0;
            op2_q       <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            mem_rd_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (bus.flush_i) begin
            out_valid <= 1'b0;
        end else if (fire) begin
            out_valid   <= 1'b1;
            inst_addr_q <= bus.inst_addr_i;
            aluop_q     <= dec.aluop;
            op1_q       <= data1;
            op2_q       <= op2_sel;
            we_q        <= dec.we;
            waddr_q     <= RADDR_W'(rd);
            mem_rd_q    <= dec.mem_rd;
            illegal_q   <= dec.illegal;
        end else if (stall && (!out_valid || bus.out_ready_i)) begin
            out_valid <= 1'b0;
            aluop_q   <= ALUOP_NOP;
            we_q      <= 1'b0;
        end else if (bus.out_ready_i && !bus.in_valid_i) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.out_valid_o = out_valid;
    assign bus.inst_addr_o = inst_addr_q;
    assign bus.aluop_o     = aluop_q;
    assign bus.op1_o       = op1_q;
    assign bus.op2_o       = op2_q;
    assign bus.reg_we_o    = we_q;
    assign bus.reg_waddr_o = waddr_q;
    assign bus.mem_rd_o    = mem_rd_q;
    assign bus.illegal_o   = illegal_q;

endmodule
